// File: rtl/reg_file_bank.sv
// General-purpose register bank: byte-masked write port, two combinational read ports,
// optional write->read forwarding and a one-deep shadow bank for context save/restore/swap.
module reg_file_bank #(
    parameter int WIDTH     = 16,
    parameter int NREGS     = 8,
    parameter int ZERO_REG0 = 0,
    parameter int BYPASS    = 1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       we,
    input  logic [$clog2(NREGS)-1:0]   waddr,
    input  logic [WIDTH-1:0]           wdata,
    input  logic [WIDTH/8-1:0]         wstrb,
    input  logic [$clog2(NREGS)-1:0]   raddr_a,
    output logic [WIDTH-1:0]           rdata_a,
    input  logic [$clog2(NREGS)-1:0]   raddr_b,
    output logic [WIDTH-1:0]           rdata_b,
    input  logic                       save,
    input  logic                       restore,
    output logic                       shadow_valid
);

    localparam int AW = $clog2(NREGS);
    localparam int NB = WIDTH / 8;

    logic [WIDTH-1:0] bank_r   [NREGS];
    logic [WIDTH-1:0] shadow_r [NREGS];
    logic             shadow_valid_r;

    logic             restore_eff_s;
    logic             write_eff_s;
    logic [WIDTH-1:0] merged_s;
    logic [WIDTH-1:0] rdata_a_s;
    logic [WIDTH-1:0] rdata_b_s;

    function automatic logic idx_in_range(input logic [AW-1:0] idx);
        return (int'(idx) < NREGS);
    endfunction

    // Register 0 is hard-wired to zero when ZERO_REG0 is set.
    function automatic logic idx_is_live(input logic [AW-1:0] idx);
        return idx_in_range(idx) && !((ZERO_REG0 != 0) && (idx == {AW{1'b0}}));
    endfunction

    function automatic logic [WIDTH-1:0] lane_merge(input logic [WIDTH-1:0] old_v,
                                                    input logic [WIDTH-1:0] new_v,
                                                    input logic [NB-1:0]    strb);
        logic [WIDTH-1:0] res;
        res = old_v;
        for (int i = 0; i < NB; i++) begin
            if (strb[i]) begin
                res[8*i +: 8] = new_v[8*i +: 8];
            end else begin
                res[8*i +: 8] = old_v[8*i +: 8];
            end
        end
        return res;
    endfunction

    // Decode which operations take effect at the coming edge; restore outranks the write.
    always_comb begin
        restore_eff_s = restore && shadow_valid_r;
        write_eff_s   = we && (wstrb != {NB{1'b0}}) && idx_is_live(waddr) && !restore_eff_s;
        if (idx_in_range(waddr)) begin
            merged_s = lane_merge(bank_r[waddr], wdata, wstrb);
        end else begin
            merged_s = wdata;
        end
    end

    // Read port A with optional forwarding of the post-edge write value.
    always_comb begin
        rdata_a_s = {WIDTH{1'b0}};
        if ((BYPASS != 0) && write_eff_s && (raddr_a == waddr)) begin
            rdata_a_s = merged_s;
        end else if (idx_is_live(raddr_a)) begin
            rdata_a_s = bank_r[raddr_a];
        end else begin
            rdata_a_s = {WIDTH{1'b0}};
        end
    end

    // Read port B, identical to port A.
    always_comb begin
        rdata_b_s = {WIDTH{1'b0}};
        if ((BYPASS != 0) && write_eff_s && (raddr_b == waddr)) begin
            rdata_b_s = merged_s;
        end else if (idx_is_live(raddr_b)) begin
            rdata_b_s = bank_r[raddr_b];
        end else begin
            rdata_b_s = {WIDTH{1'b0}};
        end
    end

    // Bank, shadow and shadow-valid update; save always captures pre-edge bank contents.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) begin
                bank_r[i]   <= {WIDTH{1'b0}};
                shadow_r[i] <= {WIDTH{1'b0}};
            end
            shadow_valid_r <= 1'b0;
        end else begin
            for (int i = 0; i < NREGS; i++) begin
                if (restore_eff_s) begin
                    bank_r[i] <= ((ZERO_REG0 != 0) && (i == 0)) ? {WIDTH{1'b0}} : shadow_r[i];
                end else if (write_eff_s && (waddr == AW'(i))) begin
                    bank_r[i] <= merged_s;
                end else begin
                    bank_r[i] <= bank_r[i];
                end
                if (save) begin
                    shadow_r[i] <= ((ZERO_REG0 != 0) && (i == 0)) ? {WIDTH{1'b0}} : bank_r[i];
                end else begin
                    shadow_r[i] <= shadow_r[i];
                end
            end
            shadow_valid_r <= shadow_valid_r | save;
        end
    end

    assign rdata_a      = rdata_a_s;
    assign rdata_b      = rdata_b_s;
    assign shadow_valid = shadow_valid_r;

endmodule

// File: tb/tb_reg_file_bank.sv
// Scoreboard bench for reg_file_bank: default, no-bypass and zero-reg0/NREGS=6 instances
// share one stimulus stream; directed expectations are queued and checked on the falling edge.
module tb_reg_file_bank;

    logic        clk = 1'b0;
    logic        reset;
    logic        we;
    logic [2:0]  waddr;
    logic [15:0] wdata;
    logic [1:0]  wstrb;
    logic [2:0]  raddr_a;
    logic [2:0]  raddr_b;
    logic        save;
    logic        restore;

    logic [15:0] d_ra, d_rb, n_ra, n_rb, z_ra, z_rb;
    logic        d_sv, n_sv, z_sv;

    int errors = 0;
    int checks = 0;

    typedef struct {
        string       name;
        int          sel;
        logic [15:0] exp_v;
    } chk_t;

    chk_t sb_q[$];

    localparam int D_A = 0, D_B = 1, D_SV = 2, N_A = 3, N_B = 4, N_SV = 5, Z_A = 6, Z_B = 7, Z_SV = 8;

    reg_file_bank #(.WIDTH(16), .NREGS(8), .ZERO_REG0(0), .BYPASS(1)) dut (
        .clk(clk), .reset(reset), .we(we), .waddr(waddr), .wdata(wdata), .wstrb(wstrb),
        .raddr_a(raddr_a), .rdata_a(d_ra), .raddr_b(raddr_b), .rdata_b(d_rb),
        .save(save), .restore(restore), .shadow_valid(d_sv));

    reg_file_bank #(.WIDTH(16), .NREGS(8), .ZERO_REG0(0), .BYPASS(0)) dut_nb (
        .clk(clk), .reset(reset), .we(we), .waddr(waddr), .wdata(wdata), .wstrb(wstrb),
        .raddr_a(raddr_a), .rdata_a(n_ra), .raddr_b(raddr_b), .rdata_b(n_rb),
        .save(save), .restore(restore), .shadow_valid(n_sv));

    reg_file_bank #(.WIDTH(16), .NREGS(6), .ZERO_REG0(1), .BYPASS(1)) dut_z (
        .clk(clk), .reset(reset), .we(we), .waddr(waddr), .wdata(wdata), .wstrb(wstrb),
        .raddr_a(raddr_a), .rdata_a(z_ra), .raddr_b(raddr_b), .rdata_b(z_rb),
        .save(save), .restore(restore), .shadow_valid(z_sv));

    always #5 clk = ~clk;

    function automatic logic [15:0] actual_of(input int sel);
        case (sel)
            D_A:     return d_ra;
            D_B:     return d_rb;
            D_SV:    return {15'd0, d_sv};
            N_A:     return n_ra;
            N_B:     return n_rb;
            N_SV:    return {15'd0, n_sv};
            Z_A:     return z_ra;
            Z_B:     return z_rb;
            Z_SV:    return {15'd0, z_sv};
            default: return 16'hxxxx;
        endcase
    endfunction

    // Monitor: compare every queued expectation against the settled outputs.
    always @(negedge clk) begin
        while (sb_q.size() > 0) begin
            chk_t c;
            logic [15:0] act;
            c   = sb_q.pop_front();
            act = actual_of(c.sel);
            checks++;
            if (act !== c.exp_v) begin
                errors++;
                $display("FAIL %s: got %h expected %h", c.name, act, c.exp_v);
            end
        end
    end

    task automatic chk(input string n, input int s, input logic [15:0] v);
        sb_q.push_back('{name: n, sel: s, exp_v: v});
    endtask

    task automatic drive(input logic w, input logic [2:0] wa, input logic [15:0] wd,
                         input logic [1:0] ws, input logic [2:0] ra, input logic [2:0] rb,
                         input logic sv, input logic rs);
        @(posedge clk);
        #1;
        we = w; waddr = wa; wdata = wd; wstrb = ws;
        raddr_a = ra; raddr_b = rb; save = sv; restore = rs;
    endtask

    task automatic pulse_reset();
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1; we = 1'b0; waddr = 3'd0; wdata = 16'h0000; wstrb = 2'b00;
        raddr_a = 3'd0; raddr_b = 3'd0; save = 1'b0; restore = 1'b0;
        chk("reset_ra", D_A, 16'h0000);
        chk("reset_sv", D_SV, 16'h0000);
        chk("reset_nb_sv", N_SV, 16'h0000);
        chk("reset_z_sv", Z_SV, 16'h0000);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Test 1: write, save, then a mid-cycle reset clears everything at once
        drive(1'b1, 3'd5, 16'hBEEF, 2'b11, 3'd5, 3'd5, 1'b0, 1'b0);
        chk("t1_bypass", D_A, 16'hBEEF);
        drive(1'b0, 3'd0, 16'h0000, 2'b00, 3'd5, 3'd5, 1'b1, 1'b0);
        chk("t1_sv_before", D_SV, 16'h0000);
        drive(1'b0, 3'd0, 16'h0000, 2'b00, 3'd5, 3'd5, 1'b0, 1'b0);
        chk("t1_sv_after", D_SV, 16'h0001);
        chk("t1_read", D_A, 16'hBEEF);
        @(posedge clk);
        #2;
        reset = 1'b1;
        chk("t1_rst_ra", D_A, 16'h0000);
        chk("t1_rst_rb", D_B, 16'h0000);
        chk("t1_rst_sv", D_SV, 16'h0000);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Test 2: byte-lane write, with and without forwarding
        drive(1'b1, 3'd3, 16'h1234, 2'b11, 3'd3, 3'd3, 1'b0, 1'b0);
        chk("t2_init_byp", D_A, 16'h1234);
        chk("t2_init_nb", N_A, 16'h0000);
        drive(1'b1, 3'd3, 16'hABCD, 2'b10, 3'd3, 3'd3, 1'b0, 1'b0);
        chk("t2_byp_a", D_A, 16'hAB34);
        chk("t2_byp_b", D_B, 16'hAB34);
        chk("t2_nb_a", N_A, 16'h1234);
        chk("t2_nb_b", N_B, 16'h1234);
        drive(1'b1, 3'd3, 16'hFFFF, 2'b00, 3'd3, 3'd3, 1'b0, 1'b0);
        chk("t2_next_a", D_A, 16'hAB34);
        chk("t2_next_nb", N_A, 16'hAB34);
        chk("t2_nostrb_byp", D_B, 16'hAB34);
        drive(1'b0, 3'd0, 16'h0000, 2'b00, 3'd3, 3'd3, 1'b0, 1'b0);
        chk("t2_nostrb_hold", D_A, 16'hAB34);
        chk("t2_nb_sv", N_SV, 16'h0000);

        // Test 3: save, overwrite, restore with a discarded same-cycle write
        drive(1'b1, 3'd1, 16'h0011, 2'b11, 3'd1, 3'd3, 1'b0, 1'b0);
        drive(1'b0, 3'd0, 16'h0000, 2'b00, 3'd1, 3'd3, 1'b1, 1'b0);
        chk("t3_saved_val", D_A, 16'h0011);
        drive(1'b1, 3'd1, 16'h00FF, 2'b11, 3'd1, 3'd3, 1'b0, 1'b0);
        chk("t3_ovr_byp", D_A, 16'h00FF);
        chk("t3_sv", D_SV, 16'h0001);
        drive(1'b1, 3'd1, 16'h0F0F, 2'b11, 3'd1, 3'd3, 1'b0, 1'b1);
        chk("t3_restore_nobyp", D_A, 16'h00FF);
        drive(1'b0, 3'd0, 16'h0000, 2'b00, 3'd1, 3'd3, 1'b0, 1'b0);
        chk("t3_restored", D_A, 16'h0011);
        chk("t3_other_reg", D_B, 16'hAB34);
        chk("t3_sv_kept", D_SV, 16'h0001);

        // Test 4: swap twice, second swap with a discarded write
        drive(1'b1, 3'd2, 16'h5555, 2'b11, 3'd2, 3'd1, 1'b0, 1'b0);
        drive(1'b0, 3'd0, 16'h0000, 2'b00, 3'd2, 3'd1, 1'b1, 1'b0);
        drive(1'b1, 3'd2, 16'hAAAA, 2'b11, 3'd2, 3'd1, 1'b0, 1'b0);
        drive(1'b0, 3'd0, 16'h0000, 2'b00, 3'd2, 3'd1, 1'b1, 1'b1);
        chk("t4_pre_swap", D_A, 16'hAAAA);
        drive(1'b1, 3'd2, 16'h1111, 2'b11, 3'd2, 3'd1, 1'b1, 1'b1);
        chk("t4_swap1", D_A, 16'h5555);
        chk("t4_swap1_sv", D_SV, 16'h0001);
        drive(1'b0, 3'd0, 16'h0000, 2'b00, 3'd2, 3'd1, 1'b0, 1'b0);
        chk("t4_swap2", D_A, 16'hAAAA);
        chk("t4_swap2_r1", D_B, 16'h0011);

        // Test 5: restore without a saved context lets the write through
        pulse_reset();
        drive(1'b1, 3'd6, 16'h2222, 2'b11, 3'd6, 3'd6, 1'b0, 1'b0);
        drive(1'b1, 3'd4, 16'h7777, 2'b11, 3'd4, 3'd6, 1'b0, 1'b1);
        chk("t5_byp", D_A, 16'h7777);
        chk("t5_other", D_B, 16'h2222);
        drive(1'b0, 3'd0, 16'h0000, 2'b00, 3'd4, 3'd6, 1'b0, 1'b0);
        chk("t5_reg4", D_A, 16'h7777);
        chk("t5_reg6", D_B, 16'h2222);
        chk("t5_sv", D_SV, 16'h0000);

        // Test 6: zero register and out-of-range indices on the 6-entry instance
        drive(1'b1, 3'd0, 16'hFFFF, 2'b11, 3'd0, 3'd0, 1'b0, 1'b0);
        chk("t6_z_r0_byp", Z_A, 16'h0000);
        chk("t6_d_r0_byp", D_A, 16'hFFFF);
        drive(1'b1, 3'd7, 16'h1234, 2'b11, 3'd0, 3'd7, 1'b0, 1'b0);
        chk("t6_z_r0", Z_A, 16'h0000);
        chk("t6_d_r0", D_A, 16'hFFFF);
        chk("t6_z_r7_byp", Z_B, 16'h0000);
        chk("t6_d_r7_byp", D_B, 16'h1234);
        drive(1'b1, 3'd5, 16'h5A5A, 2'b11, 3'd5, 3'd7, 1'b0, 1'b0);
        chk("t6_z_r5_byp", Z_A, 16'h5A5A);
        chk("t6_z_r7", Z_B, 16'h0000);
        drive(1'b0, 3'd0, 16'h0000, 2'b00, 3'd5, 3'd4, 1'b1, 1'b1);
        chk("t6_z_r5", Z_A, 16'h5A5A);
        chk("t6_z_r4", Z_B, 16'h7777);
        drive(1'b0, 3'd0, 16'h0000, 2'b00, 3'd0, 3'd5, 1'b0, 1'b1);
        chk("t6_z_r0_rest", Z_A, 16'h0000);
        chk("t6_z_sv", Z_SV, 16'h0001);

        for (int k = 0; k < 10 && sb_q.size() > 0; k++) begin
            @(negedge clk);
        end
        #1;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expected 0", sb_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
